// File: rtl/reg_writeback_queue_pkg.sv
// Shared definitions for the register-file writeback path.
//   XLEN     : architectural data width
//   REG_AW   : register address width
//   ZERO_REG : hard-wired zero register, never written or bypassed
//   wb_entry_t : one writeback request (destination register + data)
package reg_writeback_queue_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_bypass_match.sv
// Youngest-match search of pending writeback entries for one read port.
//   addr       : read-port register address
//   occupied   : valid mask in age order, bit 0 = oldest (queue head)
//   entry_rd   : destination registers in age order
//   entry_data : data in age order
//   hit        : some occupied entry targets addr (never for the zero register)
//   data       : data of the youngest matching entry, 0 on miss
import reg_writeback_queue_pkg::*;

module wb_bypass_match #(
    parameter int unsigned N     = XLEN,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = REG_AW
) (
    input  logic [AW-1:0]               addr,
    input  logic [DEPTH-1:0]            occupied,
    input  logic [DEPTH-1:0][AW-1:0]    entry_rd,
    input  logic [DEPTH-1:0][N-1:0]     entry_data,
    output logic                        hit,
    output logic [N-1:0]                data
);

    // Scan oldest to youngest so the last match found is the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (occupied[i] && (addr != AW'(ZERO_REG)) && (entry_rd[i] == addr)) begin
                hit  = 1'b1;
                data = entry_data[i];
            end
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order writeback queue in front of the register file's single write port.
//   clk, reset                 : clock, async active-high reset
//   Wr_Valid_i/Wr_Ready_o      : producer handshake (ready = not full)
//   Wr_Register_i, Wr_Data_i   : request payload; rd 0 is accepted and dropped
//   Hold_i                     : stall retirement this cycle
//   Reg_Write_o, Write_*_o     : register file write port (head entry, 0 when empty)
//   Read_Register_{1,2}_i      : decode read addresses
//   Bypass_Hit/Data_{1,2}_o    : youngest pending value for each read address
//   Count_o, Empty_o, Full_o   : occupancy
import reg_writeback_queue_pkg::*;

module reg_writeback_queue #(
    parameter int unsigned N     = XLEN,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = REG_AW
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        Wr_Valid_i,
    output logic                        Wr_Ready_o,
    input  logic [AW-1:0]               Wr_Register_i,
    input  logic [N-1:0]                Wr_Data_i,
    input  logic                        Hold_i,
    output logic                        Reg_Write_o,
    output logic [AW-1:0]               Write_Register_o,
    output logic [N-1:0]                Write_Data_o,
    input  logic [AW-1:0]               Read_Register_1_i,
    input  logic [AW-1:0]               Read_Register_2_i,
    output logic                        Bypass_Hit_1_o,
    output logic [N-1:0]                Bypass_Data_1_o,
    output logic                        Bypass_Hit_2_o,
    output logic [N-1:0]                Bypass_Data_2_o,
    output logic [$clog2(DEPTH):0]      Count_o,
    output logic                        Empty_o,
    output logic                        Full_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]              rd_ptr;
    logic [PW-1:0]              wr_ptr;
    logic [CW-1:0]              count;
    logic [DEPTH-1:0][AW-1:0]   mem_rd;
    logic [DEPTH-1:0][N-1:0]    mem_data;

    logic                       accept;
    logic                       push;
    logic                       pop;

    logic [DEPTH-1:0]           age_occ;
    logic [DEPTH-1:0][AW-1:0]   age_rd;
    logic [DEPTH-1:0][N-1:0]    age_data;

    // Occupancy flags derive from the registered count so reset clears them at once.
    assign Count_o    = count;
    assign Empty_o    = (count == '0);
    assign Full_o     = (count == CW'(DEPTH));
    assign Wr_Ready_o = !Full_o;

    // Writes to the zero register complete the handshake but are never stored.
    assign accept = Wr_Valid_i && Wr_Ready_o;
    assign push   = accept && (Wr_Register_i != AW'(ZERO_REG));
    assign pop    = !Empty_o && !Hold_i;

    assign Reg_Write_o      = pop;
    assign Write_Register_o = Empty_o ? '0 : mem_rd[rd_ptr];
    assign Write_Data_o     = Empty_o ? '0 : mem_data[rd_ptr];

    // Pointer and occupancy state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents are qualified by occupancy so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= Wr_Register_i;
            mem_data[wr_ptr] <= Wr_Data_i;
        end
    end

    // Rotate storage into age order (index 0 = head) for the bypass search.
    always_comb begin
        age_occ  = '0;
        age_rd   = '0;
        age_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age_occ[i]  = (CW'(i) < count);
            age_rd[i]   = mem_rd[rd_ptr + PW'(i)];
            age_data[i] = mem_data[rd_ptr + PW'(i)];
        end
    end

    wb_bypass_match #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_bypass_1 (
        .addr       (Read_Register_1_i),
        .occupied   (age_occ),
        .entry_rd   (age_rd),
        .entry_data (age_data),
        .hit        (Bypass_Hit_1_o),
        .data       (Bypass_Data_1_o)
    );

    wb_bypass_match #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_bypass_2 (
        .addr       (Read_Register_2_i),
        .occupied   (age_occ),
        .entry_rd   (age_rd),
        .entry_data (age_data),
        .hit        (Bypass_Hit_2_o),
        .data       (Bypass_Data_2_o)
    );

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue with hand-computed expectations.
import reg_writeback_queue_pkg::*;

module tb_reg_writeback_queue;

    logic        clk;
    logic        reset;
    logic        Wr_Valid_i;
    logic        Wr_Ready_o;
    logic [4:0]  Wr_Register_i;
    logic [31:0] Wr_Data_i;
    logic        Hold_i;
    logic        Reg_Write_o;
    logic [4:0]  Write_Register_o;
    logic [31:0] Write_Data_o;
    logic [4:0]  Read_Register_1_i;
    logic [4:0]  Read_Register_2_i;
    logic        Bypass_Hit_1_o;
    logic [31:0] Bypass_Data_1_o;
    logic        Bypass_Hit_2_o;
    logic [31:0] Bypass_Data_2_o;
    logic [2:0]  Count_o;
    logic        Empty_o;
    logic        Full_o;

    int total = 0;
    int bad   = 0;

    reg_writeback_queue dut (
        .clk               (clk),
        .reset             (reset),
        .Wr_Valid_i        (Wr_Valid_i),
        .Wr_Ready_o        (Wr_Ready_o),
        .Wr_Register_i     (Wr_Register_i),
        .Wr_Data_i         (Wr_Data_i),
        .Hold_i            (Hold_i),
        .Reg_Write_o       (Reg_Write_o),
        .Write_Register_o  (Write_Register_o),
        .Write_Data_o      (Write_Data_o),
        .Read_Register_1_i (Read_Register_1_i),
        .Read_Register_2_i (Read_Register_2_i),
        .Bypass_Hit_1_o    (Bypass_Hit_1_o),
        .Bypass_Data_1_o   (Bypass_Data_1_o),
        .Bypass_Hit_2_o    (Bypass_Hit_2_o),
        .Bypass_Data_2_o   (Bypass_Data_2_o),
        .Count_o           (Count_o),
        .Empty_o           (Empty_o),
        .Full_o            (Full_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input wb_entry_t e);
        Wr_Valid_i    = 1'b1;
        Wr_Register_i = e.rd;
        Wr_Data_i     = e.data;
        tick();
        Wr_Valid_i    = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 20 && !Empty_o; c++) tick();
        check_eq(tag, 64'(Empty_o), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    wb_entry_t fill_vec [8];
    int        pushed;
    int        retired;
    logic      acc;

    initial begin
        reset             = 1'b1;
        Wr_Valid_i        = 1'b0;
        Wr_Register_i     = '0;
        Wr_Data_i         = '0;
        Hold_i            = 1'b0;
        Read_Register_1_i = '0;
        Read_Register_2_i = '0;
        for (int i = 0; i < 8; i++) begin
            fill_vec[i].rd   = 5'(i + 1);
            fill_vec[i].data = 32'hA000_0000 + 32'(i);
        end

        // Reset state
        #2;
        check_eq("rst_count", 64'(Count_o), 64'd0);
        check_eq("rst_empty", 64'(Empty_o), 64'd1);
        check_eq("rst_full", 64'(Full_o), 64'd0);
        check_eq("rst_ready", 64'(Wr_Ready_o), 64'd1);
        check_eq("rst_regwrite", 64'(Reg_Write_o), 64'd0);
        check_eq("rst_hit1", 64'(Bypass_Hit_1_o), 64'd0);
        check_eq("rst_hit2", 64'(Bypass_Hit_2_o), 64'd0);
        tick();
        tick();
        reset = 1'b0;

        // Single write: latency of one cycle, then empty
        Wr_Valid_i    = 1'b1;
        Wr_Register_i = 5'd5;
        Wr_Data_i     = 32'hDEAD_BEEF;
        #1;
        check_eq("single_ready", 64'(Wr_Ready_o), 64'd1);
        tick();
        Wr_Valid_i = 1'b0;
        #1;
        check_eq("single_regwrite", 64'(Reg_Write_o), 64'd1);
        check_eq("single_wreg", 64'(Write_Register_o), 64'd5);
        check_eq("single_wdata", 64'(Write_Data_o), 64'hDEAD_BEEF);
        check_eq("single_count", 64'(Count_o), 64'd1);
        tick();
        check_eq("single_empty", 64'(Empty_o), 64'd1);
        check_eq("single_regwrite_off", 64'(Reg_Write_o), 64'd0);
        check_eq("single_wdata_zero", 64'(Write_Data_o), 64'd0);

        // Fill under hold, then retire 8 in order across the pointer wrap
        Hold_i = 1'b1;
        for (int i = 0; i < 4; i++) push(fill_vec[i]);
        check_eq("fill_full", 64'(Full_o), 64'd1);
        check_eq("fill_ready", 64'(Wr_Ready_o), 64'd0);
        check_eq("fill_count", 64'(Count_o), 64'd4);
        check_eq("fill_hold_nowrite", 64'(Reg_Write_o), 64'd0);
        Hold_i = 1'b0;
        #1;
        check_eq("full_release_write", 64'(Reg_Write_o), 64'd1);
        check_eq("full_no_passthru", 64'(Wr_Ready_o), 64'd0);
        pushed  = 4;
        retired = 0;
        for (int c = 0; c < 40 && retired < 8; c++) begin
            Wr_Valid_i = (pushed < 8);
            if (pushed < 8) begin
                Wr_Register_i = fill_vec[pushed].rd;
                Wr_Data_i     = fill_vec[pushed].data;
            end
            #1;
            if (Reg_Write_o) begin
                check_eq($sformatf("wrap_rd%0d", retired), 64'(Write_Register_o), 64'(fill_vec[retired].rd));
                check_eq($sformatf("wrap_data%0d", retired), 64'(Write_Data_o), 64'(fill_vec[retired].data));
                retired++;
            end
            acc = Wr_Valid_i && Wr_Ready_o;
            tick();
            if (acc) pushed++;
        end
        Wr_Valid_i = 1'b0;
        check_eq("wrap_retired", 64'(retired), 64'd8);
        check_eq("wrap_empty", 64'(Empty_o), 64'd1);

        // x0 drop
        Hold_i = 1'b1;
        push('{rd: 5'd3, data: 32'h33});
        Wr_Valid_i        = 1'b1;
        Wr_Register_i     = 5'd0;
        Wr_Data_i         = 32'h1234;
        Read_Register_1_i = 5'd0;
        #1;
        check_eq("x0_ready", 64'(Wr_Ready_o), 64'd1);
        tick();
        Wr_Valid_i = 1'b0;
        #1;
        check_eq("x0_count", 64'(Count_o), 64'd1);
        check_eq("x0_hit1", 64'(Bypass_Hit_1_o), 64'd0);
        Hold_i = 1'b0;
        #1;
        check_eq("x0_head_rd", 64'(Write_Register_o), 64'd3);
        tick();
        check_eq("x0_drained", 64'(Empty_o), 64'd1);
        push('{rd: 5'd0, data: 32'h1234});
        check_eq("x0_empty_count", 64'(Count_o), 64'd0);
        check_eq("x0_empty_nowrite", 64'(Reg_Write_o), 64'd0);

        // Bypass: youngest match wins, head searched, incoming not searched
        Hold_i = 1'b1;
        push('{rd: 5'd9, data: 32'h99});
        push('{rd: 5'd7, data: 32'h11});
        push('{rd: 5'd7, data: 32'h22});
        Wr_Valid_i        = 1'b1;
        Wr_Register_i     = 5'd12;
        Wr_Data_i         = 32'hCC;
        Read_Register_1_i = 5'd7;
        Read_Register_2_i = 5'd9;
        #1;
        check_eq("byp_hit1", 64'(Bypass_Hit_1_o), 64'd1);
        check_eq("byp_data1_young", 64'(Bypass_Data_1_o), 64'h22);
        check_eq("byp_hit2_head", 64'(Bypass_Hit_2_o), 64'd1);
        check_eq("byp_data2_head", 64'(Bypass_Data_2_o), 64'h99);
        Read_Register_2_i = 5'd12;
        #1;
        check_eq("byp_incoming_hit", 64'(Bypass_Hit_2_o), 64'd0);
        Wr_Valid_i        = 1'b0;
        Read_Register_2_i = 5'd8;
        #1;
        check_eq("byp_miss_hit", 64'(Bypass_Hit_2_o), 64'd0);
        check_eq("byp_miss_data", 64'(Bypass_Data_2_o), 64'd0);
        Hold_i = 1'b0;
        drain("byp_drain");
        check_eq("byp_after_drain", 64'(Bypass_Hit_1_o), 64'd0);

        // Push and pop in the same cycle at count 2
        Hold_i = 1'b1;
        push('{rd: 5'd10, data: 32'hA});
        push('{rd: 5'd11, data: 32'hB});
        check_eq("pp_count2", 64'(Count_o), 64'd2);
        Hold_i        = 1'b0;
        Wr_Valid_i    = 1'b1;
        Wr_Register_i = 5'd12;
        Wr_Data_i     = 32'hC;
        #1;
        check_eq("pp_write", 64'(Reg_Write_o), 64'd1);
        check_eq("pp_head10", 64'(Write_Register_o), 64'd10);
        tick();
        Wr_Valid_i = 1'b0;
        check_eq("pp_count_kept", 64'(Count_o), 64'd2);
        check_eq("pp_head11", 64'(Write_Register_o), 64'd11);
        check_eq("pp_data11", 64'(Write_Data_o), 64'hB);
        tick();
        check_eq("pp_head12", 64'(Write_Register_o), 64'd12);
        check_eq("pp_data12", 64'(Write_Data_o), 64'hC);
        check_eq("pp_count1", 64'(Count_o), 64'd1);
        tick();
        check_eq("pp_empty", 64'(Empty_o), 64'd1);

        // Asynchronous reset mid-drain with 3 entries
        Hold_i = 1'b1;
        push('{rd: 5'd1, data: 32'h1});
        push('{rd: 5'd2, data: 32'h2});
        push('{rd: 5'd3, data: 32'h3});
        Hold_i = 1'b0;
        #1;
        check_eq("mid_count3", 64'(Count_o), 64'd3);
        check_eq("mid_write", 64'(Reg_Write_o), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("arst_count", 64'(Count_o), 64'd0);
        check_eq("arst_regwrite", 64'(Reg_Write_o), 64'd0);
        check_eq("arst_ready", 64'(Wr_Ready_o), 64'd1);
        check_eq("arst_empty", 64'(Empty_o), 64'd1);
        tick();
        reset = 1'b0;
        push('{rd: 5'd6, data: 32'h66});
        check_eq("post_rst_rd", 64'(Write_Register_o), 64'd6);
        check_eq("post_rst_data", 64'(Write_Data_o), 64'h66);
        tick();
        check_eq("post_rst_empty", 64'(Empty_o), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
